// File: rtl/sa_cache_if.sv
// Request/response and refill bus of the set-associative read cache.
// master: requester plus lower-level memory; slave: the cache itself.
interface sa_cache_if #(
    parameter int unsigned ADDR_LENGTH = 10,
    parameter int unsigned BLOCK_SIZE  = 32
);
    logic [ADDR_LENGTH-1:0] addr_in;
    logic                   req_in;
    logic [7:0]             data_out;
    logic                   req_out;
    logic                   miss_out;
    logic [ADDR_LENGTH-1:0] miss_addr;
    logic [BLOCK_SIZE-1:0]  data_in;
    logic                   miss_in;

    modport master (
        output addr_in, req_in, data_in, miss_in,
        input  data_out, req_out, miss_out, miss_addr
    );

    modport slave (
        input  addr_in, req_in, data_in, miss_in,
        output data_out, req_out, miss_out, miss_addr
    );
endinterface

// File: rtl/sa_cache.sv
// N-way set-associative byte-read cache with fixed lookup latency and a
// miss/refill handshake to a block-wide lower level.
// Replacement: round-robin per set by default; define SA_CACHE_LRU_EN for true LRU.
module sa_cache #(
    parameter int unsigned SIZE        = 128,
    parameter int unsigned BLOCK_SIZE  = 32,
    parameter int unsigned WAYS        = 2,
    parameter int unsigned ADDR_LENGTH = 10,
    parameter int unsigned DELAY       = 4
) (
    input logic       clk,
    input logic       reset,
    sa_cache_if.slave bus
);
    localparam int unsigned SETS             = SIZE / BLOCK_SIZE / WAYS;
    localparam int unsigned BYTES            = BLOCK_SIZE / 8;
    localparam int unsigned BYTE_SELECT_SIZE = $clog2(BYTES);
    localparam int unsigned INDEX_SIZE       = $clog2(SETS);
    localparam int unsigned TAG_SIZE         = ADDR_LENGTH - BYTE_SELECT_SIZE - INDEX_SIZE;
    localparam int unsigned OFF_W            = (BYTE_SELECT_SIZE > 0) ? BYTE_SELECT_SIZE : 1;
    localparam int unsigned WAY_W            = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned CNT_W            = $clog2(DELAY + 1);

    localparam logic [ADDR_LENGTH-1:0] BLK_MASK = {ADDR_LENGTH{1'b1}} << BYTE_SELECT_SIZE;
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(DELAY - 1);
    localparam logic [WAY_W-1:0]       WAY_LAST = WAY_W'(WAYS - 1);

    typedef enum logic [1:0] {StIdle, StLookup, StMiss, StRespond} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_LENGTH-1:0] addr_q, addr_d;
    logic [7:0]             data_q, data_d;
    logic [ADDR_LENGTH-1:0] maddr_q, maddr_d;

    logic [WAYS-1:0]       valid_q  [SETS];
    logic [TAG_SIZE-1:0]   tag_arr  [SETS][WAYS];
    logic [BLOCK_SIZE-1:0] line_arr [SETS][WAYS];

    logic [INDEX_SIZE-1:0] set_idx;
    logic [TAG_SIZE-1:0]   req_tag;
    logic [OFF_W-1:0]      byte_off;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic                  has_free;
    logic [WAY_W-1:0]      free_way;
    logic [WAY_W-1:0]      policy_way;
    logic [WAY_W-1:0]      victim;
    logic                  fill_en;

    assign set_idx  = addr_q[BYTE_SELECT_SIZE +: INDEX_SIZE];
    assign req_tag  = addr_q[ADDR_LENGTH-1 -: TAG_SIZE];
    assign byte_off = (BYTE_SELECT_SIZE > 0) ? addr_q[OFF_W-1:0] : '0;
    assign fill_en  = (state_q == StMiss) && bus.miss_in;
    assign victim   = has_free ? free_way : policy_way;

    function automatic logic [7:0] pick_byte(input logic [BLOCK_SIZE-1:0] line,
                                             input logic [OFF_W-1:0] off);
        return line[{off, 3'b000} +: 8];
    endfunction

    // Tag compare across the indexed set and lowest-index free way search
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        has_free = 1'b0;
        free_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[set_idx][w] && (tag_arr[set_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[set_idx][w]) begin
                has_free = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

`ifdef SA_CACHE_LRU_EN
    logic [WAY_W-1:0] age_q [SETS][WAYS];
    logic             touch_en;
    logic [WAY_W-1:0] touch_way;
    logic [WAY_W-1:0] old_age;

    assign touch_en  = fill_en || ((state_q == StLookup) && (cnt_q == CNT_LAST) && hit);
    assign touch_way = fill_en ? victim : hit_way;

    // An invalid way being filled counts as the oldest, so ages stay a true
    // recency order even though they all start at zero.
    always_comb begin
        old_age    = valid_q[set_idx][touch_way] ? age_q[set_idx][touch_way] : WAY_LAST;
        policy_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (age_q[set_idx][w] == WAY_LAST) begin
                policy_way = WAY_W'(w);
            end
        end
    end

    // Age update: touched way becomes youngest, younger ways age by one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= '0;
                end
            end
        end else if (touch_en) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == touch_way) begin
                    age_q[set_idx][w] <= '0;
                end else if (age_q[set_idx][w] < old_age) begin
                    age_q[set_idx][w] <= age_q[set_idx][w] + WAY_W'(1);
                end
            end
        end
    end
`else
    logic [WAY_W-1:0] ptr_q [SETS];

    assign policy_way = ptr_q[set_idx];

    // Round-robin pointer advances on every fill into its set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
            end
        end else if (fill_en) begin
            ptr_q[set_idx] <= (ptr_q[set_idx] == WAY_LAST) ? '0 : ptr_q[set_idx] + WAY_W'(1);
        end
    end
`endif

    // Valid bits: cleared by reset, set by fills
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else if (fill_en) begin
            valid_q[set_idx][victim] <= 1'b1;
        end
    end

    // Tag and line storage: written only on fill, never cleared
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_arr[set_idx][victim]  <= req_tag;
            line_arr[set_idx][victim] <= bus.data_in;
        end
    end

    // Control state and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= 8'h00;
            maddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            maddr_q <= maddr_d;
        end
    end

    // Next-state: accept, count down the lookup, refill, respond
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        maddr_d = maddr_q;
        unique case (state_q)
            StIdle, StRespond: begin
                state_d = StIdle;
                if (bus.req_in) begin
                    addr_d  = bus.addr_in;
                    cnt_d   = '0;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    if (hit) begin
                        data_d  = pick_byte(line_arr[set_idx][hit_way], byte_off);
                        state_d = StRespond;
                    end else begin
                        maddr_d = addr_q & BLK_MASK;
                        state_d = StMiss;
                    end
                end
            end
            StMiss: begin
                if (bus.miss_in) begin
                    data_d  = pick_byte(bus.data_in, byte_off);
                    state_d = StRespond;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.req_out   = (state_q == StRespond);
    assign bus.miss_out  = (state_q == StMiss);
    assign bus.data_out  = data_q;
    assign bus.miss_addr = maddr_q;
endmodule

// File: doc/sa_cache.md
Name: sa_cache

Overview:
- Parametrised N-way set-associative read cache with a fixed lookup latency and a miss/refill handshake to the next memory level.
- Sits between a byte-read requester (upstream) and a block-wide lower-level memory (downstream).
- Supersedes the direct-mapped cache: configurable way count, per-set replacement, real refill path, one-cycle response pulse.

Parameters:
- SIZE, 128, total data capacity in bits.
- BLOCK_SIZE, 32, line size in bits; multiple of 8.
- WAYS, 2, associativity; power of 2; SIZE/BLOCK_SIZE/WAYS >= 2.
- ADDR_LENGTH, 10, byte address width.
- DELAY, 4, lookup latency in cycles; >= 1.
- Derived: SETS = SIZE/BLOCK_SIZE/WAYS; BYTE_SELECT_SIZE = clog2(BLOCK_SIZE/8); INDEX_SIZE = clog2(SETS); TAG_SIZE = ADDR_LENGTH - BYTE_SELECT_SIZE - INDEX_SIZE.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- addr_in  in  ADDR_LENGTH  upstream byte address; sampled on acceptance.
- req_in  in  1  upstream read request; accepted only in IDLE or RESPOND.
- data_out  out  8  read byte; valid while req_out=1.
- req_out  out  1  one-cycle response strobe.
- miss_out  out  1  refill request to lower level; held until fill accepted.
- miss_addr  out  ADDR_LENGTH  block-aligned refill address (byte-select bits zero).
- data_in  in  BLOCK_SIZE  refill line; byte j = data_in[8j+7:8j].
- miss_in  in  1  refill valid from lower level; sampled only in MISS.

Behaviour:
- States: IDLE, LOOKUP, MISS, RESPOND.
- Reset (reset=0, async): state=IDLE; all valid bits=0; replacement state=0; req_out=0, miss_out=0, data_out=8'h00, miss_addr=0. Data and tag arrays are not cleared. Reset mid-operation abandons the request; miss_out falls immediately without a clock edge.
- IDLE: req_in=1 at edge T latches addr_in and enters LOOKUP with counter=0.
- LOOKUP: counter increments each edge. At edge T+DELAY, compare the latched tag against all valid ways of the indexed set.
  - Hit: enter RESPOND with the hit byte; update replacement state.
  - Miss: enter MISS; miss_out=1; miss_addr = latched address with the low BYTE_SELECT_SIZE bits zeroed.
- MISS: miss_out and miss_addr held stable. On the first edge with miss_in=1:
  - write data_in into the victim way; set its tag and valid;
  - update replacement state;
  - enter RESPOND with the requested byte taken from data_in; miss_out=0.
- Victim selection: lowest-index invalid way first; otherwise per the replacement policy (see Optional Feature).
- RESPOND: req_out=1 for exactly one cycle; data_out valid.
  - req_in=1 at the edge ending RESPOND accepts a new request (goes to LOOKUP, counter=0).
  - Otherwise go to IDLE.
- Latency: hit: req_out high in the cycle following edge T+DELAY. Miss: req_out high in the cycle following fill edge F.
- Ignored inputs: req_in in LOOKUP/MISS; miss_in outside MISS.
- data_out holds its last value outside RESPOND; req_out=0 outside RESPOND.
- A hit and a fill never occur together; exactly one way is written per fill.
- Counter width clog2(DELAY+1); wraps to 0 on every acceptance.

Optional Feature:
- Macro: SA_CACHE_LRU_EN.
- Defined: true LRU. Each way has a clog2(WAYS)-bit age per set.
  - On hit or fill of way w: age[w]=0; ways with age < old age[w] increment.
  - Victim (all ways valid) = the way with age WAYS-1.
- Undefined: round-robin. Each set has a clog2(WAYS)-bit pointer.
  - Victim = pointer; the pointer increments modulo WAYS on every fill to that set.
  - Hits do not change replacement state.
- WAYS=1: both modes degenerate to direct-mapped (no replacement state).

Test Plan:
- Reset, then read 0x001 → miss_out rises at edge T+4 with miss_addr=0x000; drive miss_in=1 with data_in=0x44332211 → single req_out pulse, data_out=0x22.
- Read 0x003 after the previous fill → hit: req_out in the cycle after T+4, data_out=0x44, miss_out stays 0.
- Set 0: fill 0x000, then fill 0x008, then read 0x000 (hit), then read 0x010 (miss, fill); re-read 0x000 and 0x008.
  - Round-robin: 0x000 misses, 0x008 hits.
  - SA_CACHE_LRU_EN: 0x000 hits, 0x008 misses.
- Assert reset=0 mid-MISS → miss_out drops asynchronously; after release, read 0x001 → misses again (valid cleared).
- Pulse miss_in=1 in IDLE; hold req_in=1 throughout LOOKUP → no state change from miss_in; exactly one req_out per accepted request.
- Hold req_in=1 with a new address during RESPOND → new request accepted at that edge; next req_out 4 cycles later, no IDLE cycle between.
